rotate_match_finder: RTL and testbench



---
 rtl/rotate_match_finder_if.sv | 22 ++
 rtl/rotate_match_finder.sv | 124 ++++++++++++
 tb/tb_rotate_match_finder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rotate_match_finder_if.sv
// rtl/rotate_match_finder_if.sv - start/busy/done bundle for the rotate-amount finder
interface rotate_match_finder_if;
   logic        start;
   logic [31:0] ref_word;
   logic [31:0] rot_word;
   logic        dir;
   logic        busy;
   logic        done;
   logic        found;
   logic [4:0]  amt;
   logic [31:0] match_mask;

   modport master (
      output start, ref_word, rot_word, dir,
      input  busy, done, found, amt, match_mask
   );

   modport slave (
      input  start, ref_word, rot_word, dir,
      output busy, done, found, amt, match_mask
   );
endinterface

// File: rtl/rotate_match_finder.sv
// rtl/rotate_match_finder.sv - recovers a 32-bit rotate amount by stepping a 1-bit rotator
// Optional ROTFIND_ALL_MATCH_EN: run all 32 compares and report every matching amount in match_mask.
module rotate_match_finder (
   input  logic                  clk,
   input  logic                  reset,
   rotate_match_finder_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   state_t      state_q;
   logic [31:0] sh_q;
   logic [31:0] tgt_q;
   logic        dir_q;
   logic [4:0]  cnt_q;
   logic        busy_q;
   logic        done_q;
   logic        found_q;
   logic [4:0]  amt_q;

   logic        hit;
   logic [31:0] sh_rot;

   assign hit    = (sh_q == tgt_q);
   assign sh_rot = dir_q ? {sh_q[30:0], sh_q[31]} : {sh_q[0], sh_q[31:1]};

`ifdef ROTFIND_ALL_MATCH_EN
   logic [31:0] mask_q;
   logic [31:0] mask_d;
   logic [4:0]  low_idx;

   // Descending scan so the lowest matching amount is the one left standing.
   always_comb begin
      mask_d  = mask_q | (hit ? (32'd1 << cnt_q) : 32'd0);
      low_idx = 5'd0;
      for (int i = 31; i >= 0; i--) begin
         if (mask_d[i]) low_idx = 5'(i);
      end
   end

   assign bus.match_mask = mask_q;
`else
   assign bus.match_mask = 32'd0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         sh_q    <= 32'd0;
         tgt_q   <= 32'd0;
         dir_q   <= 1'b0;
         cnt_q   <= 5'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         found_q <= 1'b0;
         amt_q   <= 5'd0;
`ifdef ROTFIND_ALL_MATCH_EN
         mask_q  <= 32'd0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  sh_q    <= bus.ref_word;
                  tgt_q   <= bus.rot_word;
                  dir_q   <= bus.dir;
                  cnt_q   <= 5'd0;
                  busy_q  <= 1'b1;
                  found_q <= 1'b0;
                  amt_q   <= 5'd0;
`ifdef ROTFIND_ALL_MATCH_EN
                  mask_q  <= 32'd0;
`endif
                  state_q <= SEARCH;
               end
            end
            SEARCH: begin
`ifdef ROTFIND_ALL_MATCH_EN
               mask_q <= mask_d;
               if (cnt_q == 5'd31) begin
                  found_q <= |mask_d;
                  amt_q   <= low_idx;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  sh_q  <= sh_rot;
                  cnt_q <= cnt_q + 5'd1;
               end
`else
               if (hit) begin
                  found_q <= 1'b1;
                  amt_q   <= cnt_q;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else if (cnt_q == 5'd31) begin
                  found_q <= 1'b0;
                  amt_q   <= 5'd0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  sh_q  <= sh_rot;
                  cnt_q <= cnt_q + 5'd1;
               end
`endif
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.found = found_q;
   assign bus.amt   = amt_q;
endmodule

// File: tb/tb_rotate_match_finder.sv
// tb/tb_rotate_match_finder.sv - randomized self-checking bench for rotate_match_finder
module tb_rotate_match_finder;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   rotate_match_finder_if bif ();

   rotate_match_finder dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      if (obs !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, want);
      end
   endtask

   function automatic logic [31:0] rotw(input logic [31:0] x, input int k, input logic left);
      logic [63:0] d;
      d = {x, x};
      if (left) begin
         d = d << k;
         return d[63:32];
      end
      d = d >> k;
      return d[31:0];
   endfunction

   task automatic run(input logic [31:0] r, input logic [31:0] t, input logic d,
                      input bit perturb, input bit spam, input string tag);
      logic [31:0] emask;
      logic [31:0] emask_out;
      bit          efound;
      int          eamt;
      int          elat;
      int          cyc;
      emask  = 32'd0;
      efound = 0;
      eamt   = 0;
      cyc    = 0;
      for (int k = 0; k < 32; k++) if (rotw(r, k, d) == t) emask[k] = 1'b1;
      for (int k = 31; k >= 0; k--) if (emask[k]) begin efound = 1; eamt = k; end
`ifdef ROTFIND_ALL_MATCH_EN
      elat      = 32;
      emask_out = emask;
`else
      elat      = efound ? eamt + 1 : 32;
      emask_out = 32'd0;
`endif
      @(negedge clk);
      bif.ref_word = r;
      bif.rot_word = t;
      bif.dir      = d;
      bif.start    = 1'b1;
      @(negedge clk);
      bif.start = 1'b0;
      chk({tag, ".busy_on"}, 32'(bif.busy), 32'd1);
      chk({tag, ".found_clr"}, 32'(bif.found), 32'd0);
      while (1) begin
         @(negedge clk);
         cyc++;
         if (bif.done || cyc >= 40) break;
         if (perturb) begin
            bif.ref_word = $urandom;
            bif.rot_word = $urandom;
            bif.dir      = 1'($urandom_range(0, 1));
         end
         if (spam) bif.start = 1'($urandom_range(0, 1));
      end
      chk({tag, ".latency"}, 32'(cyc), 32'(elat));
      chk({tag, ".found"}, 32'(bif.found), 32'(efound));
      chk({tag, ".amt"}, 32'(bif.amt), 32'(eamt));
      chk({tag, ".mask"}, bif.match_mask, emask_out);
      chk({tag, ".busy_off"}, 32'(bif.busy), 32'd0);
      bif.start = spam;
      @(negedge clk);
      bif.start = 1'b0;
      chk({tag, ".done_pulse"}, 32'(bif.done), 32'd0);
      chk({tag, ".no_restart"}, 32'(bif.busy), 32'd0);
      chk({tag, ".amt_hold"}, 32'(bif.amt), 32'(eamt));
   endtask

   initial begin
      logic [31:0] r;
      logic [31:0] t;
      logic        d;
      reset        = 1'b1;
      bif.start    = 1'b0;
      bif.ref_word = 32'd0;
      bif.rot_word = 32'd0;
      bif.dir      = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.busy", 32'(bif.busy), 32'd0);
      chk("rst.done", 32'(bif.done), 32'd0);
      chk("rst.found", 32'(bif.found), 32'd0);
      chk("rst.amt", 32'(bif.amt), 32'd0);
      chk("rst.mask", bif.match_mask, 32'd0);
      reset = 1'b0;

      run(32'h0000_0001, 32'h0000_0100, 1'b1, 0, 0, "left8");
      run(32'h8000_0000, 32'h0000_0001, 1'b0, 0, 0, "right31");
      run(32'h1234_5678, 32'h1234_5679, 1'b1, 0, 0, "nomatch");
      run(32'h1234_5678, 32'h1234_5679, 1'b1, 1, 0, "nomatch_iso");
      run(32'h0000_00F0, 32'h0F00_0000, 1'b1, 1, 0, "iso_match");
      run(32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1, 0, 0, "periodic");
      run(32'h0000_0003, 32'hC000_0000, 1'b0, 0, 1, "busy_start");

      // Abort a no-match search partway through; outputs must clear without a clock edge.
      @(negedge clk);
      bif.ref_word = 32'h1234_5678;
      bif.rot_word = 32'h1234_5679;
      bif.dir      = 1'b1;
      bif.start    = 1'b1;
      @(negedge clk);
      bif.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid.busy_pre", 32'(bif.busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("mid.busy", 32'(bif.busy), 32'd0);
      chk("mid.done", 32'(bif.done), 32'd0);
      chk("mid.found", 32'(bif.found), 32'd0);
      chk("mid.amt", 32'(bif.amt), 32'd0);
      chk("mid.mask", bif.match_mask, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run(32'h0000_00FF, 32'hFF00_0000, 1'b1, 0, 0, "after_rst");

      for (int i = 0; i < 20; i++) begin
         r = $urandom;
         d = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) t = $urandom;
         else t = rotw(r, int'($urandom_range(0, 31)), d);
         run(r, t, d, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
